// File: rtl/tt_um_sub_unpack_pkg.sv
// Shared definitions for the serial subtract/unpack tile: FSM states,
// uio bit positions and the fixed output-enable mask.
package tt_um_sub_unpack_pkg;

    typedef enum logic {
        StWaitS,
        StWaitB
    } state_e;

    localparam int unsigned IN_VALID  = 0;
    localparam int unsigned OUT_POP   = 1;
    localparam int unsigned ABORT     = 2;
    localparam int unsigned CLR_OVF   = 3;
    localparam int unsigned OUT_VALID = 4;
    localparam int unsigned FULL      = 5;
    localparam int unsigned BORROW    = 6;
    localparam int unsigned OVF       = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    // Queue entry layout: {borrow, A}
    localparam int unsigned ENTRY_W = 9;

endpackage

// File: rtl/tt_sub_fifo.sv
// Synchronous FIFO with async active-low reset; head entry visible on dout.
// A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
module tt_sub_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Aw    = 2,
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic [Aw:0]      count
);

    localparam logic [Aw:0] DepthCnt = (Aw + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
    logic [Aw:0]      count_q;
    logic             do_pop, do_push;

    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != DepthCnt) | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/tt_um_sub_unpack.sv
// Recovers A = (S - B) mod 256 from byte-serial S, B pairs and queues {borrow, A}
// for the host to pop.
module tt_um_sub_unpack
    import tt_um_sub_unpack_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(FIFO_DEPTH);

    state_e             state_q;
    logic [7:0]         s_q;
    logic               ovf_q;
    logic [AW:0]        count;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] entry;
    logic               in_valid, out_pop, abort, clr_ovf;
    logic               out_valid, full, pop, push_ok, push, drop;
    logic               unused;

    assign in_valid = uio_in[IN_VALID];
    assign out_pop  = uio_in[OUT_POP];
    assign abort    = uio_in[ABORT];
    assign clr_ovf  = uio_in[CLR_OVF];
    assign unused   = ^{ena, uio_in[7:4]};

    assign out_valid = (count != '0);
    assign full      = (count == DepthCnt);
    assign pop       = out_pop & out_valid;
    assign push_ok   = (count < DepthCnt) | pop;
    assign push      = (state_q == StWaitB) & in_valid & ~abort & push_ok;
    assign drop      = (state_q == StWaitB) & in_valid & ~abort & ~push_ok;

    // 9-bit difference: bit 8 is the borrow out of the 8-bit subtraction
    assign entry = {1'b0, s_q} - {1'b0, ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitS;
            s_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (abort) begin
                state_q <= StWaitS;
                s_q     <= '0;
            end else if (in_valid) begin
                unique case (state_q)
                    StWaitS: begin
                        s_q     <= ui_in;
                        state_q <= StWaitB;
                    end
                    StWaitB: begin
                        if (push_ok) state_q <= StWaitS;
                    end
                    default: state_q <= StWaitS;
                endcase
            end
            // A drop in the same cycle as clr_ovf keeps the flag set
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    tt_sub_fifo #(
        .Depth (FIFO_DEPTH),
        .Aw    (AW),
        .Width (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .count (count)
    );

    assign uo_out = out_valid ? head[7:0] : 8'h00;

    always_comb begin
        uio_out            = 8'h00;
        uio_out[OUT_VALID] = out_valid;
        uio_out[FULL]      = full;
        uio_out[BORROW]    = out_valid & head[8];
        uio_out[OVF]       = ovf_q;
    end

    assign uio_oe = UIO_OE_MASK;

endmodule
